// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Latency: WIDTH+1 enabled cycles from accept to hi/lo update; done pulses the cycle after.
// Backpressure: busy stalls the CPU; start is ignored while busy; ena=0 freezes all state.
module mdu_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;    // upper WIDTH+1: partial product / remainder
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  // operand conditioning at accept
  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // one radix-2 step of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH:0]   div_next;

  // sign-corrected results
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, quo_fix, rem, rem_fix;

  // Combinational datapath: magnitudes, iteration step, final correction
  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;

    mul_sum  = acc_q[2*WIDTH:WIDTH] + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // remainder stays below the divisor, so its top bit is always clear here
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
    div_next = div_diff[WIDTH+1] ? {div_sh, acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};

    prod     = acc_q[2*WIDTH-1:0];
    prod_fix = (sa_q ^ sb_q) ? (~prod + 1'b1) : prod;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
    quo_fix  = (sa_q ^ sb_q) ? (~quo + 1'b1) : quo;
    rem_fix  = sa_q ? (~rem + 1'b1) : rem;
  end

  // Next-state and register updates for the FSM and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !op[2]) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = op[1];
          sa_d     = a_neg;
          sb_d     = b_neg;
          opnd_d   = op[1] ? b_mag : a_mag;
          acc_d    = {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
        end else if (start && op[2] && !op[1]) begin
          if (op[0]) lo_d = a;
          else       hi_d = a;
          done_d = 1'b1;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers, frozen while ena is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Iterative multiply/divide unit with HI/LO registers. It extends the single-cycle 31-instruction CPU towards the 54-instruction set by adding MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU. The CPU issues one operation with a start pulse, stalls its PC/regfile while busy is high, and reads hi/lo (MFHI/MFLO) directly. The operand width is parametrised, and the unit performs one radix-2 step per cycle.

Parameters:
WIDTH, 32, operand width and hi/lo width; must be at least 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
ena  in  1  clock enable; low freezes all state
start  in  1  operation request, sampled only when idle and ena=1
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
a  in  WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO data)
b  in  WIDTH  rt operand (multiplier or divisor)
busy  out  1  high while an iterative operation is in progress; CPU stall
done  out  1  one-cycle completion pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - Any in-flight operation is aborted with no partial result.
- ena=0:
  - No register changes, including state, counter, hi/lo and done.
  - done and busy hold their values.
  - Latency in cycles is extended by the number of disabled cycles.
- FSM states: IDLE, CALC, FIX.
  - IDLE -> CALC on start=1 with op in {MULT, MULTU, DIV, DIVU}.
  - CALC -> FIX when the counter reaches WIDTH-1 iterations done.
  - FIX -> IDLE unconditionally.
- Accept edge E0 (IDLE, ena=1, start=1):
  - a and b are latched; they may change afterwards.
  - Signed ops latch magnitudes plus sign flags sa and sb; unsigned ops latch the raw values with sa=sb=0.
- CALC performs exactly WIDTH iterations at edges E1..E_WIDTH.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, remainder register WIDTH+1 bits, quotient shifted in LSB-first.
- FIX edge E_WIDTH+1 applies sign correction and writes hi/lo.
  - MULT: {hi,lo} = two's-complement negation of the product if sa^sb.
  - DIV: lo = negated quotient if sa^sb; hi = negated remainder if sa.
  - MULTU/DIVU: no correction.
  - MULT/MULTU: hi:lo = full 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- busy is registered, high for exactly WIDTH+1 cycles after E0 (CALC plus FIX), low in IDLE.
- done is registered, high for exactly one cycle: the first IDLE cycle after FIX.
  - A start in that same cycle is accepted; back-to-back issue is allowed.
- Divide by zero (no exception, deterministic result from the algorithm):
  - DIVU: lo = all ones, hi = a.
  - DIV: lo = sa ? 1 : all ones; hi = a (original signed value).
- Signed overflow, DIV of most-negative by -1: lo = most-negative, hi = 0.
- MTHI/MTLO, accepted in IDLE only:
  - At E0, hi (MTHI) or lo (MTLO) := a; the other register is unchanged.
  - busy stays 0; done pulses in the next cycle.
- Reserved op with start=1: ignored; no state change, no done.
- start=1 while busy (CALC or FIX): ignored, including MTHI/MTLO; the operation in flight is unaffected.
- hi/lo hold their last value at all times except the FIX write and MTHI/MTLO writes; they are readable while busy (old value).

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high exactly 33 cycles, done one cycle, hi=0xFFFFFFFE lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then immediately, in the done cycle, start MULT a=0x80000000 b=0x80000000 -> accepted; hi=0x40000000 lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0. DIVU a=100 b=7 -> lo=14 hi=2.
4. DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF hi=0x1234. DIV a=0xFFFFFFF0 b=0 -> lo=1 hi=0xFFFFFFF0. Both after normal latency.
5. MTHI a=0xA5A5A5A5 -> hi=0xA5A5A5A5 next cycle, busy stays 0, done one pulse. Then start MULTU 3*5 and, during busy, start MTLO a=0xDEAD -> ignored; final hi=0 lo=15.
6. Start DIVU 1000/10:
   - Drop ena for 5 cycles mid-CALC -> busy lasts 38 cycles; lo=100 hi=0.
   - Repeat with rst pulsed mid-CALC -> busy=0, done=0, hi=lo=0 immediately, with no later done.
